mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
// - Shares the single data-memory port between the pipeline core MEM stage and one DMA requester (UART/peripheral DMA).
// - Core has priority; DMA is served in core-idle cycles.
// - An anti-starvation timer forces one DMA slot and stalls the core for that cycle.
// - Sits between pipeline_core oMem*/iMemReadData and the data RAM/peripheral bus.
// PARAMETERS
// - MAX_WAIT  8  cycles a DMA request may stay ungranted before a forced slot (1..2^WAIT_W-1)
// - WAIT_W    4  width of the wait counter
// PORTS
// - clk             in   1   system clock, all state on rising edge
// - reset           in   1   synchronous, active-high
// - iCoreAddr       in   32  core MEM-stage address
// - iCoreRead       in   1   core load this cycle
// - iCoreWrite      in   1   core store this cycle
// - iCoreWriteData  in   32  core store data
// - oCoreReadData   out  32  = iMemReadData (combinational)
// - oCoreStall      out  1   core must hold MEM stage and repeat the access next cycle
// - iDmaReq         in   1   DMA request; held high with stable addr/data/write until oDmaGrant
// - iDmaWrite       in   1   1 = write, 0 = read
// - iDmaAddr        in   32  DMA address
// - iDmaWriteData   in   32  DMA write data
// - oDmaGrant       out  1   1-cycle pulse: bus driven by DMA this cycle
// - oDmaReadData    out  32  registered read data
// - oDmaValid       out  1   1-cycle pulse, cycle after a granted DMA read
// - oMemAddr        out  32  to memory
// - oMemRead        out  1   to memory
// - oMemWrite       out  1   to memory
// - oMemWriteData   out  32  to memory
// - iMemReadData    in   32  combinational read data from memory
// BEHAVIOUR
// - coreAcc = iCoreRead | iCoreWrite. Memory read is combinational: access completes in the cycle it is driven.
// - FSM states:
//   - S_IDLE: no pending DMA.
//   - S_WAIT: DMA pending, waitCnt counting.
//   - S_FORCE: forced DMA slot.
// - S_IDLE/S_WAIT, iDmaReq & !coreAcc:
//   - grant this cycle: oMem* = DMA signals, oDmaGrant = 1.
//   - waitCnt <= 0; next state S_IDLE.
// - S_IDLE/S_WAIT, iDmaReq & coreAcc:
//   - core owns bus; waitCnt <= waitCnt+1; next state S_WAIT.
//   - When waitCnt+1 == MAX_WAIT, next state S_FORCE.
// - S_FORCE:
//   - DMA owns bus, oDmaGrant = 1, oCoreStall = coreAcc.
//   - waitCnt <= 0; next state S_IDLE.
//   - Core access is not performed that cycle (core repeats it).
// - iDmaReq low in S_WAIT (illegal withdrawal): return to S_IDLE, waitCnt <= 0, no grant.
// - Bus mux: DMA owns bus -> oMemAddr/Read/Write/WriteData from DMA; else from core. Idle bus: oMemRead = oMemWrite = 0, addr/data = core values.
// - oMemRead = !iDmaWrite and oMemWrite = iDmaWrite during a DMA slot.
// - Core read & write both high: passed through unchanged (core's responsibility).
// - DMA read grant: oDmaReadData <= iMemReadData; oDmaValid = 1 next cycle. Writes never pulse oDmaValid.
// - Back-to-back: DMA may re-request the cycle after a grant; a new request starts with waitCnt = 0.
// - oCoreStall is only ever 1 in S_FORCE, so max stall is 1 cycle per MAX_WAIT+1 cycles.
// - Reset (any state): S_IDLE, waitCnt = 0, oDmaGrant = 0, oDmaValid = 0, oDmaReadData = 0, oCoreStall = 0.
//   - A pending or forced DMA access is dropped.
//   - Requester keeps iDmaReq high and is re-arbitrated from cycle after reset.
// CONFIGURATION
// - MEMARB_PERF_CNT_EN defined:
//   - Adds 32-bit outputs oCoreAccCnt, oDmaAccCnt, oStallCnt; reset to 0.
//   - Increment on each core access performed, each oDmaGrant, each oCoreStall cycle; wrap at 2^32.
// - MEMARB_PERF_CNT_EN undefined: ports and counters absent; arbitration identical.
// TESTING
// - Core lw 0x10 every cycle, no DMA -> oMemAddr = 0x10, oMemRead = 1, oCoreReadData = mem[0x10], oDmaGrant never 1, oCoreStall = 0.
// - Core idle; DMA read 0x20 (mem = 0xCAFEBABE) -> oDmaGrant same cycle; next cycle oDmaValid = 1, oDmaReadData = 0xCAFEBABE.
// - Core accesses every cycle, DMA write 0x24 = 0x55 pending, MAX_WAIT = 8:
//   - 8 core-owned cycles, then 9th cycle oDmaGrant = 1, oCoreStall = 1, oMemWrite = 1, oMemAddr = 0x24.
//   - mem[0x24] = 0x55 afterwards.
// - Core store and DMA request on the same cycle, then core idle next cycle -> core store first, DMA granted next cycle, oCoreStall = 0.
// - reset asserted in S_FORCE cycle -> no grant; all outputs 0 next cycle; DMA with req still high granted after reset when core idle.
// - With MEMARB_PERF_CNT_EN: 5 core ops + 2 DMA grants (1 forced) -> oCoreAccCnt = 5, oDmaAccCnt = 2, oStallCnt = 1.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Purpose: bundles the core, DMA and memory-side signals of the data-memory arbiter.
// Latency: none; plain wires between the pipeline, the DMA requester, memory and the arbiter.
// Backpressure: core is held by oCoreStall; the DMA request is held until oDmaGrant.
interface mem_bus_arbiter_if;
    // core MEM stage
    logic [31:0] iCoreAddr;
    logic        iCoreRead;
    logic        iCoreWrite;
    logic [31:0] iCoreWriteData;
    logic [31:0] oCoreReadData;
    logic        oCoreStall;
    // DMA requester
    logic        iDmaReq;
    logic        iDmaWrite;
    logic [31:0] iDmaAddr;
    logic [31:0] iDmaWriteData;
    logic        oDmaGrant;
    logic [31:0] oDmaReadData;
    logic        oDmaValid;
    // memory side
    logic [31:0] oMemAddr;
    logic        oMemRead;
    logic        oMemWrite;
    logic [31:0] oMemWriteData;
    logic [31:0] iMemReadData;

    // arbiter view
    modport slave (
        input  iCoreAddr, iCoreRead, iCoreWrite, iCoreWriteData,
        output oCoreReadData, oCoreStall,
        input  iDmaReq, iDmaWrite, iDmaAddr, iDmaWriteData,
        output oDmaGrant, oDmaReadData, oDmaValid,
        output oMemAddr, oMemRead, oMemWrite, oMemWriteData,
        input  iMemReadData
    );

    // environment view (core, DMA and memory driving the arbiter)
    modport master (
        output iCoreAddr, iCoreRead, iCoreWrite, iCoreWriteData,
        input  oCoreReadData, oCoreStall,
        output iDmaReq, iDmaWrite, iDmaAddr, iDmaWriteData,
        input  oDmaGrant, oDmaReadData, oDmaValid,
        input  oMemAddr, oMemRead, oMemWrite, oMemWriteData,
        output iMemReadData
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Purpose: shares the data-memory port between the core MEM stage (priority) and one DMA requester.
// Latency: grant and memory access in the same cycle; DMA read data/valid one cycle after the grant.
// Backpressure: DMA waits for idle core cycles; after MAX_WAIT lost cycles a forced slot stalls the core once.
// Optional: define MEMARB_PERF_CNT_EN to add core-access / DMA-grant / stall counters.
module mem_bus_arbiter #(
    parameter int MAX_WAIT = 8,
    parameter int WAIT_W   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_bus_arbiter_if.slave     bus
`ifdef MEMARB_PERF_CNT_EN
    ,
    output logic [31:0]          oCoreAccCnt,
    output logic [31:0]          oDmaAccCnt,
    output logic [31:0]          oStallCnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_FORCE = 2'd2
    } state_t;

    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

    state_t            state_q;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic [WAIT_W-1:0] wait_cnt_d;
    logic              dma_vld_q;
    logic [31:0]       dma_rdata_q;

    logic core_acc;
    logic dma_own;
    logic dma_grant;

    // Ownership decode: forced slot always goes to DMA, otherwise DMA only when the core is idle.
    // Reset suppresses any grant so a pending or forced access is dropped.
    always_comb begin
        core_acc   = bus.iCoreRead | bus.iCoreWrite;
        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        dma_own    = 1'b0;
        case (state_q)
            S_FORCE: dma_own = 1'b1;
            default: dma_own = bus.iDmaReq & ~core_acc;
        endcase
        dma_grant  = dma_own & ~reset;
    end

    // Bus mux and core-facing outputs; an idle bus still presents the core address/data.
    always_comb begin
        bus.oCoreReadData = bus.iMemReadData;
        bus.oCoreStall    = ~reset & (state_q == S_FORCE) & core_acc;
        bus.oDmaGrant     = dma_grant;
        bus.oDmaReadData  = dma_rdata_q;
        bus.oDmaValid     = dma_vld_q;
        if (dma_grant) begin
            bus.oMemAddr      = bus.iDmaAddr;
            bus.oMemRead      = ~bus.iDmaWrite;
            bus.oMemWrite     = bus.iDmaWrite;
            bus.oMemWriteData = bus.iDmaWriteData;
        end else begin
            bus.oMemAddr      = bus.iCoreAddr;
            bus.oMemRead      = bus.iCoreRead;
            bus.oMemWrite     = bus.iCoreWrite;
            bus.oMemWriteData = bus.iCoreWriteData;
        end
    end

    // Arbitration FSM with wait counter and registered DMA read return.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            wait_cnt_q  <= '0;
            dma_vld_q   <= 1'b0;
            dma_rdata_q <= '0;
        end else begin
            dma_vld_q <= dma_grant & ~bus.iDmaWrite;
            if (dma_grant && !bus.iDmaWrite) begin
                dma_rdata_q <= bus.iMemReadData;
            end
            case (state_q)
                S_FORCE: begin
                    state_q    <= S_IDLE;
                    wait_cnt_q <= '0;
                end
                default: begin
                    if (bus.iDmaReq && core_acc) begin
                        // core won the bus again; escalate once the DMA has lost MAX_WAIT cycles
                        wait_cnt_q <= wait_cnt_d;
                        state_q    <= (wait_cnt_d == MAX_WAIT_C) ? S_FORCE : S_WAIT;
                    end else begin
                        // granted now, or request absent/withdrawn: start fresh
                        wait_cnt_q <= '0;
                        state_q    <= S_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef MEMARB_PERF_CNT_EN
    // Free-running performance counters; core accesses count only when actually performed.
    always_ff @(posedge clk) begin
        if (reset) begin
            oCoreAccCnt <= '0;
            oDmaAccCnt  <= '0;
            oStallCnt   <= '0;
        end else begin
            if (core_acc && !dma_own) oCoreAccCnt <= oCoreAccCnt + 32'd1;
            if (dma_grant)            oDmaAccCnt  <= oDmaAccCnt + 32'd1;
            if (bus.oCoreStall)       oStallCnt   <= oStallCnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Purpose: directed self-checking bench for mem_bus_arbiter with a small word-addressed memory model.
// Latency: inputs change 1 time unit after the rising edge; combinational outputs sampled 1 unit later.
// Backpressure: DMA request held until a grant is observed; waits bounded by cycle budgets.
module tb_mem_bus_arbiter;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    mem_bus_arbiter_if bus ();

`ifdef MEMARB_PERF_CNT_EN
    logic [31:0] core_cnt;
    logic [31:0] dma_cnt;
    logic [31:0] stall_cnt;
`endif

    mem_bus_arbiter #(.MAX_WAIT(8), .WAIT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef MEMARB_PERF_CNT_EN
        ,
        .oCoreAccCnt (core_cnt),
        .oDmaAccCnt  (dma_cnt),
        .oStallCnt   (stall_cnt)
`endif
    );

    // 256-word memory, combinational read, write on rising edge
    logic [31:0] mem [0:255];
    assign bus.iMemReadData = mem[bus.oMemAddr[9:2]];
    always @(posedge clk) begin
        if (bus.oMemWrite) mem[bus.oMemAddr[9:2]] <= bus.oMemWriteData;
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic core_set(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        bus.iCoreRead      = r;
        bus.iCoreWrite     = w;
        bus.iCoreAddr      = a;
        bus.iCoreWriteData = d;
    endtask

    task automatic dma_set(input logic req, input logic w, input logic [31:0] a, input logic [31:0] d);
        bus.iDmaReq       = req;
        bus.iDmaWrite     = w;
        bus.iDmaAddr      = a;
        bus.iDmaWriteData = d;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({bus.oDmaGrant, bus.oDmaValid, bus.oCoreStall} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_flags: got %b want 000", {bus.oDmaGrant, bus.oDmaValid, bus.oCoreStall});
        end
        n_cmp++;
        if (bus.oDmaReadData !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_rdata: got %h want 00000000", bus.oDmaReadData);
        end
        // a request during reset with an idle core must not be granted
        dma_set(1'b1, 1'b0, 32'h20, 32'h0);
        #1;
        n_cmp++;
        if ({bus.oDmaGrant, bus.oMemRead, bus.oMemWrite} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_no_grant: got %b want 000", {bus.oDmaGrant, bus.oMemRead, bus.oMemWrite});
        end
        dma_set(1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b0;
        tick();
    endtask

    task automatic preload();
        core_set(1'b0, 1'b1, 32'h10, 32'h11112222);
        tick();
        core_set(1'b0, 1'b1, 32'h20, 32'hCAFEBABE);
        tick();
        core_set(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_core_only();
        core_set(1'b1, 1'b0, 32'h10, 32'h0);
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++;
            if ({bus.oMemRead, bus.oMemWrite, bus.oDmaGrant, bus.oCoreStall} !== 4'b1000 ||
                bus.oMemAddr !== 32'h10) begin
                n_bad++;
                $display("FAIL core_only_bus[%0d]: got rd/wr/gnt/stall=%b addr=%h want 1000 addr=00000010",
                         i, {bus.oMemRead, bus.oMemWrite, bus.oDmaGrant, bus.oCoreStall}, bus.oMemAddr);
            end
            n_cmp++;
            if (bus.oCoreReadData !== 32'h11112222) begin
                n_bad++;
                $display("FAIL core_only_rdata[%0d]: got %h want 11112222", i, bus.oCoreReadData);
            end
            tick();
        end
        core_set(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_dma_read();
        dma_set(1'b1, 1'b0, 32'h20, 32'h0);
        #1;
        n_cmp++;
        if ({bus.oDmaGrant, bus.oMemRead, bus.oMemWrite} !== 3'b110 || bus.oMemAddr !== 32'h20) begin
            n_bad++;
            $display("FAIL dma_read_grant: got gnt/rd/wr=%b addr=%h want 110 addr=00000020",
                     {bus.oDmaGrant, bus.oMemRead, bus.oMemWrite}, bus.oMemAddr);
        end
        tick();
        dma_set(1'b0, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (bus.oDmaValid !== 1'b1 || bus.oDmaReadData !== 32'hCAFEBABE) begin
            n_bad++;
            $display("FAIL dma_read_data: got valid=%b data=%h want valid=1 data=cafebabe",
                     bus.oDmaValid, bus.oDmaReadData);
        end
        tick();
        n_cmp++;
        if (bus.oDmaValid !== 1'b0) begin
            n_bad++;
            $display("FAIL dma_valid_pulse: got %b want 0", bus.oDmaValid);
        end
    endtask

    task automatic test_forced_slot();
        core_set(1'b1, 1'b0, 32'h10, 32'h0);
        dma_set(1'b1, 1'b1, 32'h24, 32'h55);
        for (int i = 1; i <= 8; i++) begin
            #1;
            n_cmp++;
            if ({bus.oDmaGrant, bus.oCoreStall} !== 2'b00 || bus.oMemAddr !== 32'h10) begin
                n_bad++;
                $display("FAIL force_wait[%0d]: got gnt/stall=%b addr=%h want 00 addr=00000010",
                         i, {bus.oDmaGrant, bus.oCoreStall}, bus.oMemAddr);
            end
            tick();
        end
        #1;
        n_cmp++;
        if ({bus.oDmaGrant, bus.oCoreStall, bus.oMemRead, bus.oMemWrite} !== 4'b1101 ||
            bus.oMemAddr !== 32'h24 || bus.oMemWriteData !== 32'h55) begin
            n_bad++;
            $display("FAIL force_slot: got gnt/stall/rd/wr=%b addr=%h wd=%h want 1101 addr=00000024 wd=00000055",
                     {bus.oDmaGrant, bus.oCoreStall, bus.oMemRead, bus.oMemWrite}, bus.oMemAddr, bus.oMemWriteData);
        end
        tick();
        dma_set(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        n_cmp++;
        if ({bus.oDmaGrant, bus.oCoreStall, bus.oDmaValid} !== 3'b000) begin
            n_bad++;
            $display("FAIL force_after: got gnt/stall/valid=%b want 000",
                     {bus.oDmaGrant, bus.oCoreStall, bus.oDmaValid});
        end
        core_set(1'b1, 1'b0, 32'h24, 32'h0);
        #1;
        n_cmp++;
        if (bus.oCoreReadData !== 32'h55) begin
            n_bad++;
            $display("FAIL force_mem_written: got %h want 00000055", bus.oCoreReadData);
        end
        tick();
        core_set(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_store_then_dma();
        core_set(1'b0, 1'b1, 32'h30, 32'hA5A5A5A5);
        dma_set(1'b1, 1'b0, 32'h10, 32'h0);
        #1;
        n_cmp++;
        if ({bus.oDmaGrant, bus.oCoreStall, bus.oMemWrite} !== 3'b001 || bus.oMemAddr !== 32'h30) begin
            n_bad++;
            $display("FAIL store_first: got gnt/stall/wr=%b addr=%h want 001 addr=00000030",
                     {bus.oDmaGrant, bus.oCoreStall, bus.oMemWrite}, bus.oMemAddr);
        end
        tick();
        core_set(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        n_cmp++;
        if ({bus.oDmaGrant, bus.oCoreStall, bus.oMemRead} !== 3'b101 || bus.oMemAddr !== 32'h10) begin
            n_bad++;
            $display("FAIL dma_second: got gnt/stall/rd=%b addr=%h want 101 addr=00000010",
                     {bus.oDmaGrant, bus.oCoreStall, bus.oMemRead}, bus.oMemAddr);
        end
        tick();
        dma_set(1'b0, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (bus.oDmaValid !== 1'b1 || bus.oDmaReadData !== 32'h11112222) begin
            n_bad++;
            $display("FAIL dma_second_data: got valid=%b data=%h want valid=1 data=11112222",
                     bus.oDmaValid, bus.oDmaReadData);
        end
        core_set(1'b1, 1'b0, 32'h30, 32'h0);
        #1;
        n_cmp++;
        if (bus.oCoreReadData !== 32'hA5A5A5A5) begin
            n_bad++;
            $display("FAIL store_mem_written: got %h want a5a5a5a5", bus.oCoreReadData);
        end
        tick();
        core_set(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_back_to_back();
        int first_gnt;
        int second_gnt;
        int n_gnt;
        int n_stall;
        first_gnt  = 0;
        second_gnt = 0;
        n_gnt      = 0;
        n_stall    = 0;
        // idle core: consecutive requests granted on consecutive cycles
        dma_set(1'b1, 1'b0, 32'h20, 32'h0);
        #1;
        n_cmp++;
        if (bus.oDmaGrant !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_first_grant: got %b want 1", bus.oDmaGrant);
        end
        tick();
        n_cmp++;
        if (bus.oDmaValid !== 1'b1 || bus.oDmaReadData !== 32'hCAFEBABE || bus.oDmaGrant !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_second_grant: got valid=%b data=%h gnt=%b want 1 cafebabe 1",
                     bus.oDmaValid, bus.oDmaReadData, bus.oDmaGrant);
        end
        tick();
        // busy core: each new request restarts the wait count, so forced slots land on cycles 9 and 18
        core_set(1'b1, 1'b0, 32'h10, 32'h0);
        for (int c = 1; c <= 20; c++) begin
            #1;
            if (bus.oDmaGrant === 1'b1) begin
                n_gnt++;
                if (n_gnt == 1) first_gnt = c;
                if (n_gnt == 2) second_gnt = c;
            end
            if (bus.oCoreStall === 1'b1) n_stall++;
            tick();
        end
        dma_set(1'b0, 1'b0, 32'h0, 32'h0);
        core_set(1'b0, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (first_gnt !== 9 || second_gnt !== 18) begin
            n_bad++;
            $display("FAIL b2b_forced_cycles: got %0d,%0d want 9,18 (0 = not seen within budget)",
                     first_gnt, second_gnt);
        end
        n_cmp++;
        if (n_gnt !== 2 || n_stall !== 2) begin
            n_bad++;
            $display("FAIL b2b_counts: got grants=%0d stalls=%0d want 2,2", n_gnt, n_stall);
        end
        tick();
    endtask

    task automatic test_reset_in_force();
        core_set(1'b1, 1'b0, 32'h10, 32'h0);
        dma_set(1'b1, 1'b1, 32'h40, 32'h77);
        for (int i = 0; i < 8; i++) tick();
        // this is the forced-slot cycle
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({bus.oDmaGrant, bus.oCoreStall, bus.oMemWrite} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_in_force: got gnt/stall/wr=%b want 000",
                     {bus.oDmaGrant, bus.oCoreStall, bus.oMemWrite});
        end
        tick();
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({bus.oDmaGrant, bus.oCoreStall, bus.oDmaValid} !== 3'b000 || bus.oDmaReadData !== 32'h0) begin
            n_bad++;
            $display("FAIL after_reset_outputs: got gnt/stall/valid=%b data=%h want 000 00000000",
                     {bus.oDmaGrant, bus.oCoreStall, bus.oDmaValid}, bus.oDmaReadData);
        end
        tick();
        core_set(1'b0, 1'b0, 32'h0, 32'h0);
        #1;
        n_cmp++;
        if ({bus.oDmaGrant, bus.oMemWrite} !== 2'b11 || bus.oMemAddr !== 32'h40) begin
            n_bad++;
            $display("FAIL regrant_after_reset: got gnt/wr=%b addr=%h want 11 addr=00000040",
                     {bus.oDmaGrant, bus.oMemWrite}, bus.oMemAddr);
        end
        tick();
        dma_set(1'b0, 1'b0, 32'h0, 32'h0);
        core_set(1'b1, 1'b0, 32'h40, 32'h0);
        #1;
        n_cmp++;
        if (bus.oCoreReadData !== 32'h77) begin
            n_bad++;
            $display("FAIL regrant_mem_written: got %h want 00000077", bus.oCoreReadData);
        end
        tick();
        core_set(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

`ifdef MEMARB_PERF_CNT_EN
    task automatic test_perf_cnt();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++;
        if (core_cnt !== 32'd0 || dma_cnt !== 32'd0 || stall_cnt !== 32'd0) begin
            n_bad++;
            $display("FAIL perf_reset: got %0d/%0d/%0d want 0/0/0", core_cnt, dma_cnt, stall_cnt);
        end
        // one idle-core grant, then 8 core reads followed by a forced write that stalls the core
        dma_set(1'b1, 1'b0, 32'h20, 32'h0);
        tick();
        core_set(1'b1, 1'b0, 32'h10, 32'h0);
        dma_set(1'b1, 1'b1, 32'h44, 32'h9);
        for (int i = 0; i < 9; i++) tick();
        dma_set(1'b0, 1'b0, 32'h0, 32'h0);
        core_set(1'b0, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (core_cnt !== 32'd8 || dma_cnt !== 32'd2 || stall_cnt !== 32'd1) begin
            n_bad++;
            $display("FAIL perf_counts: got core=%0d dma=%0d stall=%0d want 8/2/1", core_cnt, dma_cnt, stall_cnt);
        end
        tick();
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        core_set(1'b0, 1'b0, 32'h0, 32'h0);
        dma_set(1'b0, 1'b0, 32'h0, 32'h0);
        test_reset();
        preload();
        test_core_only();
        test_dma_read();
        test_forced_slot();
        test_store_then_dma();
        test_back_to_back();
        test_reset_in_force();
`ifdef MEMARB_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
